// File: rtl/ula_sequenciador_if.sv
// Bundle of the two requester channels, the shared ALU drive/return and the
// sequencer status outputs. The sequencer uses the slave view; the
// requesters and the ALU use the master view.
interface ula_sequenciador_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             req0, req1;
  logic [4:0]       op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [SHW-1:0]   cnt0, cnt1;
  logic             ack0, ack1;

  logic [WIDTH-1:0] ula_a, ula_b;
  logic [4:0]       ula_op;
  logic [WIDTH-1:0] ula_result;
  logic             ula_o, ula_c, ula_s, ula_z;

  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             done, done_id, busy;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, cnt0, cnt1,
    input  ula_result, ula_o, ula_c, ula_s, ula_z,
    output ack0, ack1, ula_a, ula_b, ula_op,
    output result, flags, done, done_id, busy
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, cnt0, cnt1,
    output ula_result, ula_o, ula_c, ula_s, ula_z,
    input  ack0, ack1, ula_a, ula_b, ula_op,
    input  result, flags, done, done_id, busy
  );
endinterface

// File: rtl/ula_sequenciador.sv
// Shares one combinational ALU between two requesters (round-robin), runs
// N-bit shifts as N passes of the ALU's 1-bit shift, and owns the
// architectural {O,C,S,Z} flag register.
//
// state   | meaning
// IDLE    | waiting for a request; ula_* hold their last drive
// EXEC    | first ALU pass on latched operands (only pass for non-shifts)
// SHIFT   | further 1-bit shift passes, feeding the result back into ula_a
// DONE    | completion pulse; no grant possible here
module ula_sequenciador #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic              clock,
  input logic              reset,
  ula_sequenciador_if.slave bus
);

  localparam logic [4:0] OP_SHL   = 5'b01000;
  localparam logic [4:0] OP_SHR   = 5'b01001;
  localparam logic [4:0] OP_PASSA = 5'b10101;
  localparam logic [4:0] OP_ZEROS = 5'b10000;
  localparam logic [4:0] OP_ONES  = 5'b11111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             gid_q, gid_d;
  logic [4:0]       op_q, op_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0] ula_a_q, ula_a_d;
  logic [WIDTH-1:0] ula_b_q, ula_b_d;
  logic [4:0]       ula_op_q, ula_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             done_q, done_d, done_id_q, done_id_d;

  logic             gnt, finish;
  logic [4:0]       sel_op;
  logic [SHW-1:0]   sel_cnt;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic is_arith(input logic [4:0] op);
    return (op == 5'b00000) || (op == 5'b00001) || (op == 5'b00011) ||
           (op == 5'b00100) || (op == 5'b00101) || (op == 5'b00110);
  endfunction

  // Each op class touches only its own flags; a zero-count shift is a pass
  // that clears C instead of taking it from the ALU.
  function automatic logic [3:0] flags_next(input logic [4:0] op, input logic zero_shift,
                                            input logic [3:0] cur, input logic o, c, s, z);
    logic [3:0] f;
    f = cur;
    if (is_arith(op))        f = {o, c, s, z};
    else if (is_shift(op))   f = {cur[3], zero_shift ? 1'b0 : c, s, z};
    else if (op == OP_ONES)  f = cur;
    else if (op == OP_ZEROS) f = {cur[3:1], z};
    else                     f = {cur[3:2], s, z};
    return f;
  endfunction

  // Next-state, grant and datapath updates; registers hold by default.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    gid_d     = gid_q;
    op_d      = op_q;
    rem_d     = rem_q;
    ula_a_d   = ula_a_q;
    ula_b_d   = ula_b_q;
    ula_op_d  = ula_op_q;
    result_d  = result_q;
    flags_d   = flags_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    finish    = 1'b0;
    gnt       = (bus.req0 && bus.req1) ? prio_q : bus.req1;
    sel_op    = gnt ? bus.op1 : bus.op0;
    sel_cnt   = gnt ? bus.cnt1 : bus.cnt0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gid_d    = gnt;
          prio_d   = ~gnt;
          ack0_d   = ~gnt;
          ack1_d   = gnt;
          op_d     = sel_op;
          rem_d    = sel_cnt;
          ula_a_d  = gnt ? bus.a1 : bus.a0;
          ula_b_d  = gnt ? bus.b1 : bus.b0;
          ula_op_d = (is_shift(sel_op) && sel_cnt == '0) ? OP_PASSA : sel_op;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_shift(op_q) && rem_q > SHW'(1)) begin
          ula_a_d = bus.ula_result;
          rem_d   = rem_q - SHW'(1);
          state_d = S_SHIFT;
        end else begin
          finish = 1'b1;
        end
      end
      S_SHIFT: begin
        if (rem_q == SHW'(1)) begin
          finish = 1'b1;
        end else begin
          ula_a_d = bus.ula_result;
          rem_d   = rem_q - SHW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      result_d  = bus.ula_result;
      flags_d   = flags_next(op_q, is_shift(op_q) && rem_q == '0, flags_q,
                             bus.ula_o, bus.ula_c, bus.ula_s, bus.ula_z);
      done_d    = 1'b1;
      done_id_d = gid_q;
      state_d   = S_DONE;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      prio_q    <= 1'b0;
      gid_q     <= 1'b0;
      op_q      <= '0;
      rem_q     <= '0;
      ula_a_q   <= '0;
      ula_b_q   <= '0;
      ula_op_q  <= OP_ZEROS;
      result_q  <= '0;
      flags_q   <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gid_q     <= gid_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      ula_a_q   <= ula_a_d;
      ula_b_q   <= ula_b_d;
      ula_op_q  <= ula_op_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.ula_a   = ula_a_q;
  assign bus.ula_b   = ula_b_q;
  assign bus.ula_op  = ula_op_q;
  assign bus.result  = result_q;
  assign bus.flags   = flags_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with a small behavioural ALU.
module tb_ula_sequenciador;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  ula_sequenciador_if #(.WIDTH(32), .SHW(5)) bus ();

  ula_sequenciador #(.WIDTH(32), .SHW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural ALU: add/sub, 1-bit shifts, passa, zeros, ones, default AND.
  logic [32:0] alu_t;
  logic [31:0] alu_r;
  logic        alu_o, alu_c;
  always_comb begin
    alu_t = '0;
    alu_r = bus.ula_a & bus.ula_b;
    alu_o = 1'b0;
    alu_c = 1'b0;
    case (bus.ula_op)
      5'b00000: begin
        alu_t = {1'b0, bus.ula_a} + {1'b0, bus.ula_b};
        alu_r = alu_t[31:0];
        alu_c = alu_t[32];
        alu_o = (bus.ula_a[31] == bus.ula_b[31]) && (alu_r[31] != bus.ula_a[31]);
      end
      5'b00001: begin
        alu_t = {1'b0, bus.ula_a} - {1'b0, bus.ula_b};
        alu_r = alu_t[31:0];
        alu_c = alu_t[32];
        alu_o = (bus.ula_a[31] != bus.ula_b[31]) && (alu_r[31] != bus.ula_a[31]);
      end
      5'b01000: begin alu_r = {bus.ula_a[30:0], 1'b0}; alu_c = bus.ula_a[31]; end
      5'b01001: begin alu_r = {bus.ula_a[31], bus.ula_a[31:1]}; alu_c = bus.ula_a[0]; end
      5'b10101: alu_r = bus.ula_a;
      5'b10000: alu_r = 32'd0;
      5'b11111: alu_r = 32'd1;
      default:  alu_r = bus.ula_a & bus.ula_b;
    endcase
  end
  assign bus.ula_result = alu_r;
  assign bus.ula_o      = alu_o;
  assign bus.ula_c      = alu_c;
  assign bus.ula_s      = alu_r[31];
  assign bus.ula_z      = (alu_r == 32'd0);

  // Issue one request and report ack/done latency (cycles after request edge).
  task automatic do_op(input logic id, input logic [4:0] op, input logic [31:0] a, b,
                       input logic [4:0] cnt, output int ack_n, output int done_n,
                       output logic [31:0] res, output logic [3:0] fl, output logic did,
                       output logic [4:0] exec_op);
    int n;
    ack_n = -1; done_n = -1; res = 'x; fl = 'x; did = 1'bx; exec_op = 'x;
    if (id) begin bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.cnt1 = cnt; bus.req1 = 1'b1; end
    else    begin bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.cnt0 = cnt; bus.req0 = 1'b1; end
    n = 0;
    while (n < 100 && done_n < 0) begin
      @(posedge clock); #1; n++;
      if (ack_n < 0 && (id ? bus.ack1 : bus.ack0)) begin
        ack_n = n; exec_op = bus.ula_op;
        if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      end
      if (bus.done) begin done_n = n; res = bus.result; fl = bus.flags; did = bus.done_id; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    cmp_cnt++; if (bus.ack0 !== 1'b0) begin err_cnt++; $display("FAIL reset_ack0 got %b want 0", bus.ack0); end
    cmp_cnt++; if (bus.ack1 !== 1'b0) begin err_cnt++; $display("FAIL reset_ack1 got %b want 0", bus.ack1); end
    cmp_cnt++; if (bus.done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", bus.done); end
    cmp_cnt++; if (bus.done_id !== 1'b0) begin err_cnt++; $display("FAIL reset_done_id got %b want 0", bus.done_id); end
    cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    cmp_cnt++; if (bus.result !== 32'd0) begin err_cnt++; $display("FAIL reset_result got %h want 0", bus.result); end
    cmp_cnt++; if (bus.flags !== 4'd0) begin err_cnt++; $display("FAIL reset_flags got %b want 0000", bus.flags); end
    cmp_cnt++; if (bus.ula_a !== 32'd0) begin err_cnt++; $display("FAIL reset_ula_a got %h want 0", bus.ula_a); end
    cmp_cnt++; if (bus.ula_b !== 32'd0) begin err_cnt++; $display("FAIL reset_ula_b got %h want 0", bus.ula_b); end
    cmp_cnt++; if (bus.ula_op !== 5'b10000) begin err_cnt++; $display("FAIL reset_ula_op got %b want 10000", bus.ula_op); end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_add();
    int an, dn; logic [31:0] r; logic [3:0] f; logic d; logic [4:0] eo;
    do_op(1'b0, 5'b00000, 32'h7FFFFFFF, 32'd1, 5'd0, an, dn, r, f, d, eo);
    cmp_cnt++; if (an !== 1) begin err_cnt++; $display("FAIL add_ack_lat got %0d want 1", an); end
    cmp_cnt++; if (dn !== 2) begin err_cnt++; $display("FAIL add_done_lat got %0d want 2", dn); end
    cmp_cnt++; if (r !== 32'h80000000) begin err_cnt++; $display("FAIL add_result got %h want 80000000", r); end
    cmp_cnt++; if (f !== 4'b1010) begin err_cnt++; $display("FAIL add_flags got %b want 1010", f); end
    cmp_cnt++; if (d !== 1'b0) begin err_cnt++; $display("FAIL add_done_id got %b want 0", d); end
  endtask

  task automatic test_arbitration();
    int n, ng, nd;
    int gid[4], gcy[4], did_a[4];
    logic [31:0] dres[4];
    for (int i = 0; i < 4; i++) begin gid[i] = -1; gcy[i] = -100; did_a[i] = -1; dres[i] = 'x; end
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1; reset = 1'b1;
    bus.op0 = 5'b00000; bus.a0 = 32'd1;  bus.b0 = 32'd2;  bus.cnt0 = 5'd0;
    bus.op1 = 5'b00000; bus.a1 = 32'd10; bus.b1 = 32'd20; bus.cnt1 = 5'd0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n = 0; ng = 0; nd = 0;
    while (nd < 4 && n < 80) begin
      @(posedge clock); #1; n++;
      if (ng < 4 && bus.ack0) begin gid[ng] = 0; gcy[ng] = n; ng++; end
      else if (ng < 4 && bus.ack1) begin gid[ng] = 1; gcy[ng] = n; ng++; end
      if (bus.done) begin did_a[nd] = int'(bus.done_id); dres[nd] = bus.result; nd++; end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++; if (gid[i] !== (i % 2)) begin err_cnt++; $display("FAIL arb_grant%0d got %0d want %0d", i, gid[i], i % 2); end
      cmp_cnt++; if (did_a[i] !== (i % 2)) begin err_cnt++; $display("FAIL arb_done_id%0d got %0d want %0d", i, did_a[i], i % 2); end
      cmp_cnt++; if (dres[i] !== ((i % 2) ? 32'd30 : 32'd3)) begin err_cnt++; $display("FAIL arb_result%0d got %h want %h", i, dres[i], (i % 2) ? 32'd30 : 32'd3); end
    end
    for (int i = 1; i < 4; i++) begin
      cmp_cnt++; if (gcy[i] - gcy[i-1] !== 3) begin err_cnt++; $display("FAIL arb_spacing%0d got %0d want 3", i, gcy[i] - gcy[i-1]); end
    end
  endtask

  task automatic test_shift_left();
    int an, dn; logic [31:0] r; logic [3:0] f; logic d; logic [4:0] eo;
    do_op(1'b0, 5'b00000, 32'h7FFFFFFF, 32'd1, 5'd0, an, dn, r, f, d, eo);
    cmp_cnt++; if (f !== 4'b1010) begin err_cnt++; $display("FAIL shl_pre_flags got %b want 1010", f); end
    do_op(1'b0, 5'b01000, 32'h80000001, 32'd0, 5'd3, an, dn, r, f, d, eo);
    cmp_cnt++; if (an !== 1) begin err_cnt++; $display("FAIL shl3_ack_lat got %0d want 1", an); end
    cmp_cnt++; if (dn !== 4) begin err_cnt++; $display("FAIL shl3_done_lat got %0d want 4", dn); end
    cmp_cnt++; if (r !== 32'h00000008) begin err_cnt++; $display("FAIL shl3_result got %h want 00000008", r); end
    cmp_cnt++; if (f !== 4'b1000) begin err_cnt++; $display("FAIL shl3_flags got %b want 1000", f); end
  endtask

  task automatic test_shift_right();
    int an, dn; logic [31:0] r; logic [3:0] f; logic d; logic [4:0] eo;
    do_op(1'b1, 5'b00000, 32'hFFFFFFFF, 32'h80000000, 5'd0, an, dn, r, f, d, eo);
    cmp_cnt++; if (f !== 4'b1100) begin err_cnt++; $display("FAIL shr_pre_flags got %b want 1100", f); end
    do_op(1'b1, 5'b01001, 32'h80000000, 32'd0, 5'd4, an, dn, r, f, d, eo);
    cmp_cnt++; if (dn !== 5) begin err_cnt++; $display("FAIL shr4_done_lat got %0d want 5", dn); end
    cmp_cnt++; if (r !== 32'hF8000000) begin err_cnt++; $display("FAIL shr4_result got %h want F8000000", r); end
    cmp_cnt++; if (f !== 4'b1010) begin err_cnt++; $display("FAIL shr4_flags got %b want 1010", f); end
    cmp_cnt++; if (d !== 1'b1) begin err_cnt++; $display("FAIL shr4_done_id got %b want 1", d); end
    do_op(1'b0, 5'b00000, 32'hFFFFFFFF, 32'h80000000, 5'd0, an, dn, r, f, d, eo);
    do_op(1'b0, 5'b01001, 32'h80000000, 32'h00001234, 5'd0, an, dn, r, f, d, eo);
    cmp_cnt++; if (eo !== 5'b10101) begin err_cnt++; $display("FAIL shr0_exec_op got %b want 10101", eo); end
    cmp_cnt++; if (dn !== 2) begin err_cnt++; $display("FAIL shr0_done_lat got %0d want 2", dn); end
    cmp_cnt++; if (r !== 32'h80000000) begin err_cnt++; $display("FAIL shr0_result got %h want 80000000", r); end
    cmp_cnt++; if (f !== 4'b1010) begin err_cnt++; $display("FAIL shr0_flags got %b want 1010", f); end
    do_op(1'b0, 5'b01001, 32'h80000001, 32'd0, 5'd1, an, dn, r, f, d, eo);
    cmp_cnt++; if (dn !== 2) begin err_cnt++; $display("FAIL shr1_done_lat got %0d want 2", dn); end
    cmp_cnt++; if (r !== 32'hC0000000) begin err_cnt++; $display("FAIL shr1_result got %h want C0000000", r); end
    cmp_cnt++; if (f !== 4'b1110) begin err_cnt++; $display("FAIL shr1_flags got %b want 1110", f); end
  endtask

  task automatic test_ones_zeros();
    int an, dn; logic [31:0] r; logic [3:0] f; logic d; logic [4:0] eo;
    do_op(1'b0, 5'b00000, 32'h7FFFFFFF, 32'd1, 5'd0, an, dn, r, f, d, eo);
    do_op(1'b1, 5'b11111, 32'h12345678, 32'h0, 5'd0, an, dn, r, f, d, eo);
    cmp_cnt++; if (r !== 32'd1) begin err_cnt++; $display("FAIL ones_result got %h want 1", r); end
    cmp_cnt++; if (f !== 4'b1010) begin err_cnt++; $display("FAIL ones_flags got %b want 1010", f); end
    do_op(1'b0, 5'b10000, 32'h12345678, 32'h0, 5'd0, an, dn, r, f, d, eo);
    cmp_cnt++; if (r !== 32'd0) begin err_cnt++; $display("FAIL zeros_result got %h want 0", r); end
    cmp_cnt++; if (f !== 4'b1011) begin err_cnt++; $display("FAIL zeros_flags got %b want 1011", f); end
    do_op(1'b0, 5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, an, dn, r, f, d, eo);
    cmp_cnt++; if (r !== 32'hF000F000) begin err_cnt++; $display("FAIL other_result got %h want F000F000", r); end
    cmp_cnt++; if (f !== 4'b1010) begin err_cnt++; $display("FAIL other_flags got %b want 1010", f); end
  endtask

  task automatic test_reset_mid_op();
    int n, an, dn; logic got, seen_done; logic [31:0] r; logic [3:0] f; logic d; logic [4:0] eo;
    bus.op0 = 5'b01000; bus.a0 = 32'd1; bus.b0 = 32'd0; bus.cnt0 = 5'd20; bus.req0 = 1'b1;
    n = 0; got = 1'b0; seen_done = 1'b0;
    while (!got && n < 20) begin @(posedge clock); #1; n++; if (bus.ack0) got = 1'b1; end
    bus.req0 = 1'b0;
    cmp_cnt++; if (got !== 1'b1) begin err_cnt++; $display("FAIL midrst_ack got %b want 1", got); end
    repeat (5) begin @(posedge clock); #1; if (bus.done) seen_done = 1'b1; end
    cmp_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy_before got %b want 1", bus.busy); end
    reset = 1'b0;
    @(posedge clock); #1;
    cmp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    cmp_cnt++; if (bus.flags !== 4'd0) begin err_cnt++; $display("FAIL midrst_flags got %b want 0000", bus.flags); end
    cmp_cnt++; if (bus.ula_a !== 32'd0) begin err_cnt++; $display("FAIL midrst_ula_a got %h want 0", bus.ula_a); end
    cmp_cnt++; if (bus.ula_op !== 5'b10000) begin err_cnt++; $display("FAIL midrst_ula_op got %b want 10000", bus.ula_op); end
    reset = 1'b1;
    repeat (3) begin @(posedge clock); #1; if (bus.done) seen_done = 1'b1; end
    cmp_cnt++; if (seen_done !== 1'b0) begin err_cnt++; $display("FAIL midrst_no_done got %b want 0", seen_done); end
    do_op(1'b1, 5'b00000, 32'd5, 32'd6, 5'd0, an, dn, r, f, d, eo);
    cmp_cnt++; if (an !== 1) begin err_cnt++; $display("FAIL post_ack_lat got %0d want 1", an); end
    cmp_cnt++; if (dn !== 2) begin err_cnt++; $display("FAIL post_done_lat got %0d want 2", dn); end
    cmp_cnt++; if (r !== 32'd11) begin err_cnt++; $display("FAIL post_result got %h want 0000000b", r); end
    cmp_cnt++; if (d !== 1'b1) begin err_cnt++; $display("FAIL post_done_id got %b want 1", d); end
    cmp_cnt++; if (f !== 4'b0000) begin err_cnt++; $display("FAIL post_flags got %b want 0000", f); end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = '0; bus.op1 = '0; bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.cnt0 = '0; bus.cnt1 = '0;
    test_reset();
    test_add();
    test_arbitration();
    test_shift_left();
    test_shift_right();
    test_ones_zeros();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end
endmodule
